// File: rtl/gmsk_mem_arb.sv
// Single-port memory arbiter for the GMSK-P1 core: fetch and load/store share one
// memory port, data wins by default, and a burst counter keeps fetch from starving.
module gmsk_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  stall_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_D = 2'd1;
  localparam logic [1:0] GNT_I = 2'd2;
  localparam logic [3:0] MAXB  = 4'(MAX_DBURST);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [3:0]          dcnt_r;
  logic                m_req_r;
  logic                m_we_r;
  logic [ADDR_W-1:0]   m_addr_r;
  logic [DATA_W-1:0]   m_wdata_r;
  logic [DATA_W/8-1:0] m_wstrb_r;
  logic                idle_s;
  logic                burst_ok_s;
  logic                grant_d_s;
  logic                grant_i_s;

  assign idle_s     = (state_r == IDLE);
  assign burst_ok_s = (dcnt_r < MAXB);
  // Data wins unless fetch is waiting and the data burst budget is spent.
  assign grant_d_s  = idle_s & d_req & (~if_req | burst_ok_s);
  assign grant_i_s  = idle_s & ~grant_d_s & if_req;

  // Next-state selection for the grant FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nxt_s = GNT_D;
        end else if (grant_i_s) begin
          state_nxt_s = GNT_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_D, GNT_I: begin
        if (m_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state and the registered memory request strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      m_req_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      m_req_r <= (state_nxt_s != IDLE);
    end
  end

  // Latch the winner's request fields at grant time; they stay frozen until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we_r    <= 1'b0;
      m_addr_r  <= '0;
      m_wdata_r <= '0;
      m_wstrb_r <= '0;
    end else if (grant_d_s) begin
      m_we_r    <= d_we;
      m_addr_r  <= d_addr;
      m_wdata_r <= d_wdata;
      m_wstrb_r <= d_wstrb;
    end else if (grant_i_s) begin
      m_we_r    <= 1'b0;
      m_addr_r  <= if_addr;
      m_wdata_r <= '0;
      m_wstrb_r <= '0;
    end else begin
      m_we_r    <= m_we_r;
      m_addr_r  <= m_addr_r;
      m_wdata_r <= m_wdata_r;
      m_wstrb_r <= m_wstrb_r;
    end
  end

  // Consecutive data grants seen while fetch was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_r <= 4'd0;
    end else if (grant_d_s) begin
      if (if_req && burst_ok_s) begin
        dcnt_r <= dcnt_r + 4'd1;
      end else if (if_req) begin
        dcnt_r <= dcnt_r;
      end else begin
        dcnt_r <= 4'd0;
      end
    end else if (grant_i_s) begin
      dcnt_r <= 4'd0;
    end else begin
      dcnt_r <= dcnt_r;
    end
  end

  assign m_req    = m_req_r;
  assign m_we     = m_we_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign m_wstrb  = m_wstrb_r;
  assign if_ack   = (state_r == GNT_I) & m_ack;
  assign d_ack    = (state_r == GNT_D) & m_ack;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  assign stall_o  = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_gmsk_mem_arb.sv
// Directed bench for gmsk_mem_arb: a per-cycle vector table plus hand-written
// sequences for the starvation guard and reset during a transaction.
module tb_gmsk_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  gmsk_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_DBURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic        dr;   logic        dwe;  logic [31:0] da;  logic [31:0] dwd; logic [3:0] dws;
    logic [31:0] mrd;  logic        mack;
    logic        e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwd; logic [3:0] e_mws;
    logic        e_iack; logic e_dack; logic [31:0] e_rd; logic e_stall; logic [3:0] e_dcnt;
  } vec_t;

  vec_t vecs[$];
  int   acks[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0;
    d_wdata = 32'h0; d_wstrb = 4'h0; m_rdata = 32'h0; m_ack = 1'b0;
  endtask

  initial begin
    // columns: ir ia | dr dwe da dwd dws | mrd mack || mreq mwe maddr mwd mws iack dack rd stall dcnt
    // single fetch, one wait cycle
    vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0});
    vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0});
    vecs.push_back('{1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h00100093, 1'b1,
                     1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00100093, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0});
    // contention: data first, then fetch
    vecs.push_back('{1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0});
    vecs.push_back('{1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h12345678, 1'b1,
                     1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 4'd1});
    vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd1});
    vecs.push_back('{1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1,
                     1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0});
    // store with three wait states
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0,
                       1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 32'h0, 1'b0, 4'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0,
                     1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0});
    // stray m_ack in IDLE is ignored
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h55AA55AA, 1'b1,
                     1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0});

    // reset with random inputs
    rst_n = 1'b0;
    if_req = 1'($urandom); if_addr = $urandom; d_req = 1'($urandom); d_we = 1'($urandom);
    d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom); m_rdata = $urandom;
    m_ack = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_mreq", 64'(m_req), 64'h0);
    chk("rst_iack", 64'(if_ack), 64'h0);
    chk("rst_dack", 64'(d_ack), 64'h0);
    chk("rst_dcnt", 64'(dut.dcnt_r), 64'h0);
    chk("rst_mwe", 64'(m_we), 64'h0);
    chk("rst_maddr", 64'(m_addr), 64'h0);
    chk("rst_mwdata", 64'(m_wdata), 64'h0);
    chk("rst_mwstrb", 64'(m_wstrb), 64'h0);
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_mreq", k), 64'(m_req), 64'h0);
    end

    // table-driven vectors, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      if_req = vecs[i].ir; if_addr = vecs[i].ia; d_req = vecs[i].dr; d_we = vecs[i].dwe;
      d_addr = vecs[i].da; d_wdata = vecs[i].dwd; d_wstrb = vecs[i].dws;
      m_rdata = vecs[i].mrd; m_ack = vecs[i].mack;
      @(negedge clk);
      chk($sformatf("v%0d_mreq", i),   64'(m_req),   64'(vecs[i].e_mreq));
      chk($sformatf("v%0d_mwe", i),    64'(m_we),    64'(vecs[i].e_mwe));
      chk($sformatf("v%0d_maddr", i),  64'(m_addr),  64'(vecs[i].e_maddr));
      chk($sformatf("v%0d_mwdata", i), 64'(m_wdata), 64'(vecs[i].e_mwd));
      chk($sformatf("v%0d_mwstrb", i), 64'(m_wstrb), 64'(vecs[i].e_mws));
      chk($sformatf("v%0d_iack", i),   64'(if_ack),  64'(vecs[i].e_iack));
      chk($sformatf("v%0d_dack", i),   64'(d_ack),   64'(vecs[i].e_dack));
      chk($sformatf("v%0d_stall", i),  64'(stall_o), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d_dcnt", i),   64'(dut.dcnt_r), 64'(vecs[i].e_dcnt));
      if (vecs[i].e_iack) chk($sformatf("v%0d_irdata", i), 64'(if_rdata), 64'(vecs[i].e_rd));
      if (vecs[i].e_dack && !vecs[i].dwe)
        chk($sformatf("v%0d_drdata", i), 64'(d_rdata), 64'(vecs[i].e_rd));
    end

    // starvation guard: back-to-back stores with fetch held, zero-wait memory
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300;
      d_wdata = 32'h0000_00A0 + 32'(k); d_wstrb = 4'hF; m_ack = m_req;
      @(negedge clk);
      if (d_ack) acks.push_back(0);
      if (if_ack) acks.push_back(1);
    end
    chk("starve_count", 64'(acks.size()), 64'd6);
    for (int k = 0; k < acks.size() && k < 6; k++)
      chk($sformatf("starve_ack%0d", k), 64'(acks[k]), (k == 4) ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(posedge clk);

    // reset in the middle of a fetch
    #1;
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mreq_before", 64'(m_req), 64'h1);
    chk("mid_maddr_before", 64'(m_addr), 64'h40);
    rst_n = 1'b0;
    m_ack = 1'b1;
    #1;
    chk("mid_mreq_rst", 64'(m_req), 64'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("mid_iack_rst%0d", k), 64'(if_ack), 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; m_ack = 1'b0; if_addr = 32'h44;
    @(negedge clk);
    chk("mid_idle_mreq", 64'(m_req), 64'h0);
    chk("mid_idle_iack", 64'(if_ack), 64'h0);
    @(posedge clk); #1;
    m_ack = 1'b1; m_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("mid_fresh_mreq", 64'(m_req), 64'h1);
    chk("mid_fresh_maddr", 64'(m_addr), 64'h44);
    chk("mid_fresh_iack", 64'(if_ack), 64'h1);
    chk("mid_fresh_rdata", 64'(if_rdata), 64'hA5A5A5A5);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("mid_final_mreq", 64'(m_req), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
